fetch_unit: RTL

- Instruction fetch stage. Produces the instruction stream consumed by the control-word decoder: opcode, funct3 and funct7 fields plus the instruction word and its PC.
- Owns the fetch PC and drives the instruction-cache read port with a single outstanding request.
- Buffers returned instructions in a small FIFO so decode back-pressure and cache latency are decoupled.
- Accepts redirects from branches, jal and jalr; squashes stale responses that arrive after a redirect.

---
 rtl/fetch_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding I-cache read, small FIFO to decode.
// Define FETCH_PERF_EN to add the fetched/squashed performance counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_read,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_rdata,
  input  logic        inst_resp,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [6:0]  if_opcode,
  output logic [2:0]  if_funct3,
  output logic [6:0]  if_funct7
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {REQ, SQUASH} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] req_addr;
  logic        outstanding;
  logic [31:0] fifo_inst [DEPTH];
  logic [31:0] fifo_pc   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic start;
  logic take;
  logic push;
  logic pop;

  assign start = !rst && state == REQ && !outstanding
              && count < FULL && !redirect;
  assign inst_read = !rst && (outstanding || start);
  // The address stays on the stale request while a squash is pending.
  assign inst_addr = outstanding ? {req_addr[31:2], 2'b00}
                                 : {fetch_pc[31:2], 2'b00};

  assign take = inst_read && inst_resp;
  assign push = take && !redirect && state == REQ;
  assign pop  = if_valid && id_ready && !redirect;

  assign if_valid  = count != '0;
  assign if_inst   = if_valid ? fifo_inst[rd_ptr] : '0;
  assign if_pc     = if_valid ? fifo_pc[rd_ptr] : '0;
  assign if_opcode = if_inst[6:0];
  assign if_funct3 = if_inst[14:12];
  assign if_funct7 = if_inst[31:25];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= inst_rdata;
      fifo_pc[wr_ptr]   <= {fetch_pc[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= REQ;
      fetch_pc    <= RESET_PC;
      req_addr    <= RESET_PC;
      outstanding <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      outstanding <= inst_read && !inst_resp;
      if (start)
        req_addr <= fetch_pc;
      unique case (1'b1)
        redirect: begin
          fetch_pc <= {redirect_pc[31:2], 2'b00};
          rd_ptr   <= '0;
          wr_ptr   <= '0;
          count    <= '0;
          state    <= (outstanding && !inst_resp) ? SQUASH : REQ;
        end
        default: begin
          if (push) begin
            wr_ptr   <= wr_ptr + 1'b1;
            fetch_pc <= fetch_pc + 32'd4;
          end
          if (pop)
            rd_ptr <= rd_ptr + 1'b1;
          count <= count + (AW+1)'(push) - (AW+1)'(pop);
          if (take && state == SQUASH)
            state <= REQ;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      if (pop)
        perf_fetched <= perf_fetched + 32'd1;
      if (take && (redirect || state == SQUASH))
        perf_squashed <= perf_squashed + 32'd1;
    end
  end
`endif

endmodule
